rom_dl_arbiter: RTL and testbench
=================================

// Module: rom_dl_arbiter
// PURPOSE
//  Owns the single-port program ROM RAM and the HPS download path. Sequences ROM loading
//  (ioctl_index 0), latches game-select (index 1) and DIP bytes (index 254), holds the game
//  core in reset during and after a load, and serves CPU reads when the core runs.
// PARAMETERS
//  AW          16   ROM address width; ROM_SIZE = 2**AW bytes
//  MEM_LAT     1    memory read latency in clocks (1..3)
//  HOLD_CYCLES 256  clocks core_reset stays high after download ends (>=1)
// PORTS
//  clk_25         in   1     system clock, same clock as hps_io clk_sys
//  reset          in   1     synchronous, active-high
//  ioctl_download in   1     download window active
//  ioctl_wr       in   1     one-cycle byte strobe
//  ioctl_addr     in   25    byte address within image
//  ioctl_dout     in   8     byte data
//  ioctl_index    in   8     image index: 0 ROM, 1 game select, 254 DIPs
//  cpu_rd         in   1     one-cycle read request
//  cpu_addr       in   AW    read address
//  cpu_data       out  8     read data, valid with cpu_ack
//  cpu_ack        out  1     one-cycle read completion
//  mem_addr       out  AW    RAM address
//  mem_din        out  8     RAM write data
//  mem_we         out  1     RAM write enable
//  mem_dout       in   8     RAM read data, MEM_LAT clocks after address
//  core_reset     out  1     game core reset, active-high
//  mod_sel        out  8     latched game-select byte
//  dip_sw         out  64    DIP bytes 0..7, byte k at [8k+7:8k]
//  ovf            out  1     sticky: ROM write beyond ROM_SIZE in last load
// BEHAVIOUR
//  Reset: state=RUN_WAIT, core_reset=1, hold counter=HOLD_CYCLES, cpu_ack=0, mem_we=0,
//   mem_addr=0, mem_din=0, cpu_data=0, mod_sel=0, dip_sw=0, ovf=0; in-flight read dropped.
//  States: LOAD (ioctl_download & ioctl_index==0), HOLD (counting), RUN (core live).
//   Any -> LOAD when ioctl_download=1 and ioctl_index==0; ovf cleared on entry; core_reset=1.
//   LOAD -> HOLD on ioctl_download falling; counter reloads HOLD_CYCLES.
//   HOLD -> RUN when counter reaches 0 (decrement each clock); core_reset drops on the RUN
//   clock, i.e. exactly HOLD_CYCLES clocks after the download falling edge is sampled.
//   Reset enters HOLD directly (RUN_WAIT == HOLD with full count).
//  ROM writes (LOAD only, ioctl_wr=1, index 0): ioctl_wr at clock N -> mem_we=1 at N+1 with
//   registered addr/data; one write per clock max. ioctl_addr >= ROM_SIZE: write suppressed,
//   ovf set. ioctl_wr while ioctl_download=0: ignored.
//  Non-ROM indices: index 1 write -> mod_sel<=ioctl_dout (last byte wins), any state, no
//   core reset. index 254 and ioctl_addr[24:3]==0 -> dip_sw byte ioctl_addr[2:0]; others ignored.
//  CPU reads (RUN only): cpu_rd at N -> mem_addr=cpu_addr at N+1; cpu_ack=1 and
//   cpu_data=mem_dout at N+1+MEM_LAT. One read outstanding; cpu_rd while busy is ignored
//   (CPU must wait for cpu_ack). cpu_rd in LOAD/HOLD: ignored, no ack.
//  Simultaneous: download start while read in flight -> read aborted, no ack, LOAD wins.
//   Write and read never coincide (disjoint states). ioctl_index 0 download and reset on
//   same clock -> reset wins; LOAD entered next clock if download still active.
//  cpu_data holds last value between acks; mem_addr holds last driven address.
// TESTING
//  Load 4 bytes AA,BB,CC,DD at 0..3, index 0 -> mem_we 4 pulses, each 1 clock after ioctl_wr,
//   addr 0..3 data matches; core_reset high throughout, low HOLD_CYCLES clocks after end.
//  Write addr 0x10000 with AW=16 -> no mem_we, ovf=1; next load start clears ovf.
//  Index 1 byte 02 then index 254 bytes 11..88 at 0..7, addr 8 byte FF -> mod_sel=02,
//   dip_sw=0x8877665544332211, byte FF ignored, core_reset unchanged.
//  RUN, cpu_rd addr 0x0002, MEM_LAT=1 -> mem_addr=2 next clock, cpu_ack one clock later with
//   CC; second cpu_rd during busy ignored.
//  Read in flight then ioctl_download rises with index 0 -> no cpu_ack, core_reset=1 next clock.
//  Reset asserted mid-load -> all outputs to reset values, mem_we=0 next clock, HOLD restarts.

Source files
------------

// File: rtl/rom_dl_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : rom_dl_arbiter
// Purpose  : Owns the program ROM RAM port. Sequences HPS ROM downloads
//            (index 0). Latches game-select (index 1) and DIP bytes
//            (index 254). Holds the game core in reset during and after a
//            load, and serves single-outstanding CPU reads while the core runs.
// Revision : 1.0 - initial release
// ============================================================================
module rom_dl_arbiter #(
    parameter int AW          = 16,
    parameter int MEM_LAT     = 1,
    parameter int HOLD_CYCLES = 256
) (
    input  logic          clk_25_i,
    input  logic          reset_i,
    input  logic          ioctl_download_i,
    input  logic          ioctl_wr_i,
    input  logic [24:0]   ioctl_addr_i,
    input  logic [7:0]    ioctl_dout_i,
    input  logic [7:0]    ioctl_index_i,
    input  logic          cpu_rd_i,
    input  logic [AW-1:0] cpu_addr_i,
    output logic [7:0]    cpu_data_o,
    output logic          cpu_ack_o,
    output logic [AW-1:0] mem_addr_o,
    output logic [7:0]    mem_din_o,
    output logic          mem_we_o,
    input  logic [7:0]    mem_dout_i,
    output logic          core_reset_o,
    output logic [7:0]    mod_sel_o,
    output logic [63:0]   dip_sw_o,
    output logic          ovf_o
);

    localparam int CW = $clog2(HOLD_CYCLES + 1);
    localparam int LW = $clog2(MEM_LAT + 1);

    typedef enum logic [1:0] {
        ST_LOAD = 2'd0,
        ST_HOLD = 2'd1,
        ST_RUN  = 2'd2
    } state_t;

    state_t          state_q;
    logic [CW-1:0]   hold_cnt_q;
    logic [LW-1:0]   lat_cnt_q;
    logic            busy_q;
    logic [7:0]      cpu_data_q;
    logic            cpu_ack_q;
    logic [AW-1:0]   mem_addr_q;
    logic [7:0]      mem_din_q;
    logic            mem_we_q;
    logic            core_reset_q;
    logic [7:0]      mod_sel_q;
    logic [63:0]     dip_sw_q;
    logic            ovf_q;

    // Download decode: a ROM load is requested whenever index 0 is streaming
    logic w_load_req;
    logic w_rom_wr;
    logic w_addr_ovf;
    logic w_idx_wr;

    assign w_load_req = ioctl_download_i && (ioctl_index_i == 8'd0);
    assign w_rom_wr   = w_load_req && ioctl_wr_i;
    assign w_addr_ovf = |ioctl_addr_i[24:AW];
    assign w_idx_wr   = ioctl_download_i && ioctl_wr_i;

    // Control FSM, ROM write path, CPU read path and option latches
    always_ff @(posedge clk_25_i) begin
        if (reset_i) begin
            state_q      <= ST_HOLD;
            hold_cnt_q   <= CW'(HOLD_CYCLES);
            lat_cnt_q    <= '0;
            busy_q       <= 1'b0;
            cpu_data_q   <= 8'd0;
            cpu_ack_q    <= 1'b0;
            mem_addr_q   <= '0;
            mem_din_q    <= 8'd0;
            mem_we_q     <= 1'b0;
            core_reset_q <= 1'b1;
            mod_sel_q    <= 8'd0;
            dip_sw_q     <= 64'd0;
            ovf_q        <= 1'b0;
        end else begin
            mem_we_q  <= 1'b0;
            cpu_ack_q <= 1'b0;

            case (state_q)
                ST_LOAD: begin
                    // Stay in LOAD until the download window closes, even if
                    // the index changes mid-window.
                    if (!ioctl_download_i) begin
                        state_q    <= ST_HOLD;
                        hold_cnt_q <= CW'(HOLD_CYCLES);
                    end
                end
                ST_HOLD: begin
                    if (w_load_req) begin
                        state_q      <= ST_LOAD;
                        core_reset_q <= 1'b1;
                        ovf_q        <= 1'b0;
                    end else if (hold_cnt_q <= CW'(1)) begin
                        state_q      <= ST_RUN;
                        hold_cnt_q   <= '0;
                        core_reset_q <= 1'b0;
                    end else begin
                        hold_cnt_q <= hold_cnt_q - CW'(1);
                    end
                end
                ST_RUN: begin
                    if (w_load_req) begin
                        // A new load aborts any in-flight read without an ack
                        state_q      <= ST_LOAD;
                        core_reset_q <= 1'b1;
                        ovf_q        <= 1'b0;
                        busy_q       <= 1'b0;
                    end else if (busy_q) begin
                        if (lat_cnt_q <= LW'(1)) begin
                            cpu_ack_q  <= 1'b1;
                            cpu_data_q <= mem_dout_i;
                            busy_q     <= 1'b0;
                        end else begin
                            lat_cnt_q <= lat_cnt_q - LW'(1);
                        end
                    end else if (cpu_rd_i) begin
                        mem_addr_q <= cpu_addr_i;
                        busy_q     <= 1'b1;
                        lat_cnt_q  <= LW'(MEM_LAT);
                    end
                end
                default: begin
                    state_q      <= ST_HOLD;
                    hold_cnt_q   <= CW'(HOLD_CYCLES);
                    core_reset_q <= 1'b1;
                    busy_q       <= 1'b0;
                end
            endcase

            // ROM writes only happen while the load condition holds, which
            // never overlaps a CPU read, so the address register is not shared.
            if (w_rom_wr) begin
                if (w_addr_ovf) begin
                    ovf_q <= 1'b1;
                end else begin
                    mem_we_q   <= 1'b1;
                    mem_addr_q <= ioctl_addr_i[AW-1:0];
                    mem_din_q  <= ioctl_dout_i;
                end
            end

            if (w_idx_wr && (ioctl_index_i == 8'd1)) begin
                mod_sel_q <= ioctl_dout_i;
            end

            if (w_idx_wr && (ioctl_index_i == 8'd254) && (ioctl_addr_i[24:3] == 22'd0)) begin
                dip_sw_q[{ioctl_addr_i[2:0], 3'b000} +: 8] <= ioctl_dout_i;
            end
        end
    end

    assign cpu_data_o   = cpu_data_q;
    assign cpu_ack_o    = cpu_ack_q;
    assign mem_addr_o   = mem_addr_q;
    assign mem_din_o    = mem_din_q;
    assign mem_we_o     = mem_we_q;
    assign core_reset_o = core_reset_q;
    assign mod_sel_o    = mod_sel_q;
    assign dip_sw_o     = dip_sw_q;
    assign ovf_o        = ovf_q;

endmodule
`default_nettype wire

// File: tb/tb_rom_dl_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_rom_dl_arbiter
// Purpose  : Self-checking bench for rom_dl_arbiter with a byte RAM model
//            and expectation queues for RAM writes and CPU read completions.
// Revision : 1.0 - initial release
// ============================================================================
module tb_rom_dl_arbiter;

    localparam int AW      = 16;
    localparam int MEM_LAT = 1;
    localparam int HOLD    = 8;

    logic          clk = 1'b0;
    logic          reset;
    logic          dl;
    logic          wr;
    logic [24:0]   ioaddr;
    logic [7:0]    iodout;
    logic [7:0]    idx;
    logic          cpu_rd;
    logic [AW-1:0] cpu_addr;
    logic [7:0]    cpu_data;
    logic          cpu_ack;
    logic [AW-1:0] mem_addr;
    logic [7:0]    mem_din;
    logic          mem_we;
    logic [7:0]    mem_dout;
    logic          core_reset;
    logic [7:0]    mod_sel;
    logic [63:0]   dip_sw;
    logic          ovf;

    rom_dl_arbiter #(.AW(AW), .MEM_LAT(MEM_LAT), .HOLD_CYCLES(HOLD)) dut (
        .clk_25_i         (clk),
        .reset_i          (reset),
        .ioctl_download_i (dl),
        .ioctl_wr_i       (wr),
        .ioctl_addr_i     (ioaddr),
        .ioctl_dout_i     (iodout),
        .ioctl_index_i    (idx),
        .cpu_rd_i         (cpu_rd),
        .cpu_addr_i       (cpu_addr),
        .cpu_data_o       (cpu_data),
        .cpu_ack_o        (cpu_ack),
        .mem_addr_o       (mem_addr),
        .mem_din_o        (mem_din),
        .mem_we_o         (mem_we),
        .mem_dout_i       (mem_dout),
        .core_reset_o     (core_reset),
        .mod_sel_o        (mod_sel),
        .dip_sw_o         (dip_sw),
        .ovf_o            (ovf)
    );

    always #5 clk = ~clk;

    // RAM model: asynchronous read, so data is sampled one clock after the address
    logic [7:0] mem [0:(1<<AW)-1];
    always @(posedge clk) if (mem_we) mem[mem_addr] <= mem_din;
    assign mem_dout = mem[mem_addr];

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [15:0] addr;
        logic [7:0]  data;
        int          cyc;
    } exp_t;

    exp_t wq[$];
    exp_t rq[$];

    // Scoreboard: every RAM write and every read ack must match an expectation
    always @(negedge clk) begin
        if (mem_we) begin
            checks++;
            if (wq.size() == 0) begin
                errors++;
                $display("FAIL mem_we_unexpected addr=%h din=%h cyc=%0d", mem_addr, mem_din, cyc);
            end else begin
                exp_t e;
                e = wq.pop_front();
                if (mem_addr !== e.addr || mem_din !== e.data || cyc !== e.cyc) begin
                    errors++;
                    $display("FAIL mem_write got addr=%h din=%h cyc=%0d want addr=%h din=%h cyc=%0d",
                             mem_addr, mem_din, cyc, e.addr, e.data, e.cyc);
                end
            end
        end
        if (cpu_ack) begin
            checks++;
            if (rq.size() == 0) begin
                errors++;
                $display("FAIL cpu_ack_unexpected data=%h cyc=%0d", cpu_data, cyc);
            end else begin
                exp_t e;
                e = rq.pop_front();
                if (cpu_data !== e.data || cyc !== e.cyc) begin
                    errors++;
                    $display("FAIL cpu_read got data=%h cyc=%0d want data=%h cyc=%0d",
                             cpu_data, cyc, e.data, e.cyc);
                end
            end
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Counts clocks until core_reset drops (bounded); n is returned
    task automatic measure_hold(output int n);
        n = 0;
        forever begin
            @(negedge clk);
            if (!core_reset || n >= HOLD + 20) break;
            tick();
            n++;
        end
    endtask

    task automatic rom_write(input logic [24:0] a, input logic [7:0] d, input bit expect_we);
        wr     = 1'b1;
        ioaddr = a;
        iodout = d;
        if (expect_we) wq.push_back('{a[15:0], d, cyc + 1});
        tick();
        wr = 1'b0;
    endtask

    task automatic test_reset;
        int n;
        reset = 1'b1;
        tick();
        tick();
        @(negedge clk);
        checks++;
        if ({core_reset, mem_we, cpu_ack, ovf} !== 4'b1000) begin
            errors++;
            $display("FAIL reset_flags got %b want 1000", {core_reset, mem_we, cpu_ack, ovf});
        end
        checks++;
        if ({mem_addr, mem_din, cpu_data, mod_sel} !== 40'd0) begin
            errors++;
            $display("FAIL reset_regs got %h want 0", {mem_addr, mem_din, cpu_data, mod_sel});
        end
        checks++;
        if (dip_sw !== 64'd0) begin
            errors++;
            $display("FAIL reset_dip got %h want 0", dip_sw);
        end
        tick();
        reset = 1'b0;
        measure_hold(n);
        checks++;
        if (n !== HOLD) begin
            errors++;
            $display("FAIL reset_hold_len got %0d want %0d", n, HOLD);
        end
    endtask

    task automatic test_rom_load;
        int n;
        dl  = 1'b1;
        idx = 8'd0;
        tick();
        rom_write(25'd0, 8'hAA, 1'b1);
        rom_write(25'd1, 8'hBB, 1'b1);
        tick();
        rom_write(25'd2, 8'hCC, 1'b1);
        rom_write(25'd3, 8'hDD, 1'b1);
        tick();
        @(negedge clk);
        checks++;
        if (core_reset !== 1'b1) begin
            errors++;
            $display("FAIL load_core_reset got %b want 1", core_reset);
        end
        tick();
        dl = 1'b0;
        measure_hold(n);
        checks++;
        if (n !== HOLD + 1) begin
            errors++;
            $display("FAIL load_hold_len got %0d want %0d", n, HOLD + 1);
        end
        checks++;
        if (wq.size() !== 0) begin
            errors++;
            $display("FAIL load_writes_missing got %0d pending want 0", wq.size());
        end
    endtask

    task automatic test_overflow;
        int n;
        dl  = 1'b1;
        idx = 8'd0;
        tick();
        rom_write(25'h10000, 8'h5A, 1'b0);
        tick();
        dl = 1'b0;
        tick();
        tick();
        @(negedge clk);
        checks++;
        if (ovf !== 1'b1) begin
            errors++;
            $display("FAIL ovf_set got %b want 1", ovf);
        end
        tick();
        dl = 1'b1;
        tick();
        @(negedge clk);
        checks++;
        if (ovf !== 1'b0) begin
            errors++;
            $display("FAIL ovf_clear_on_load got %b want 0", ovf);
        end
        tick();
        dl = 1'b0;
        measure_hold(n);
        checks++;
        if (n !== HOLD + 1) begin
            errors++;
            $display("FAIL ovf_hold_len got %0d want %0d", n, HOLD + 1);
        end
    endtask

    task automatic test_options;
        dl  = 1'b1;
        idx = 8'd1;
        rom_write(25'd0, 8'h07, 1'b0);
        rom_write(25'd0, 8'h02, 1'b0);
        idx = 8'd254;
        for (int k = 0; k < 8; k++) rom_write(25'(k), 8'(8'h11 * (k + 1)), 1'b0);
        rom_write(25'd8, 8'hFF, 1'b0);
        dl = 1'b0;
        tick();
        @(negedge clk);
        checks++;
        if (mod_sel !== 8'h02) begin
            errors++;
            $display("FAIL mod_sel got %h want 02", mod_sel);
        end
        checks++;
        if (dip_sw !== 64'h8877665544332211) begin
            errors++;
            $display("FAIL dip_sw got %h want 8877665544332211", dip_sw);
        end
        checks++;
        if (core_reset !== 1'b0) begin
            errors++;
            $display("FAIL options_core_reset got %b want 0", core_reset);
        end
    endtask

    task automatic test_cpu_read;
        tick();
        cpu_rd   = 1'b1;
        cpu_addr = 16'h0002;
        rq.push_back('{16'h0002, 8'hCC, cyc + 2});
        tick();
        cpu_addr = 16'h0003;
        @(negedge clk);
        checks++;
        if (mem_addr !== 16'h0002) begin
            errors++;
            $display("FAIL read_mem_addr got %h want 0002", mem_addr);
        end
        tick();
        cpu_rd = 1'b0;
        tick();
        tick();
        @(negedge clk);
        checks++;
        if (cpu_data !== 8'hCC) begin
            errors++;
            $display("FAIL read_data_hold got %h want cc", cpu_data);
        end
        // Back-to-back reads, each issued right after the previous ack
        cpu_rd   = 1'b1;
        cpu_addr = 16'h0000;
        rq.push_back('{16'h0000, 8'hAA, cyc + 2});
        tick();
        cpu_rd = 1'b0;
        tick();
        cpu_rd   = 1'b1;
        cpu_addr = 16'h0003;
        rq.push_back('{16'h0003, 8'hDD, cyc + 2});
        tick();
        cpu_rd = 1'b0;
        tick();
        tick();
        checks++;
        if (rq.size() !== 0) begin
            errors++;
            $display("FAIL read_acks_missing got %0d pending want 0", rq.size());
        end
    endtask

    task automatic test_abort;
        int n;
        cpu_rd   = 1'b1;
        cpu_addr = 16'h0001;
        tick();
        cpu_rd = 1'b0;
        dl     = 1'b1;
        idx    = 8'd0;
        tick();
        @(negedge clk);
        checks++;
        if (core_reset !== 1'b1 || cpu_ack !== 1'b0) begin
            errors++;
            $display("FAIL abort_state got core_reset=%b ack=%b want 1 0", core_reset, cpu_ack);
        end
        tick();
        tick();
        tick();
        checks++;
        if (cpu_data !== 8'hDD) begin
            errors++;
            $display("FAIL abort_data_hold got %h want dd", cpu_data);
        end
        dl = 1'b0;
        measure_hold(n);
        checks++;
        if (n !== HOLD + 1) begin
            errors++;
            $display("FAIL abort_hold_len got %0d want %0d", n, HOLD + 1);
        end
    endtask

    task automatic test_reset_midload;
        int n;
        dl  = 1'b1;
        idx = 8'd0;
        tick();
        rom_write(25'd5, 8'h77, 1'b1);
        rom_write(25'h10000, 8'h01, 1'b0);
        reset = 1'b1;
        rom_write(25'd6, 8'h66, 1'b0);
        reset = 1'b0;
        @(negedge clk);
        checks++;
        if ({core_reset, mem_we, cpu_ack, ovf} !== 4'b1000) begin
            errors++;
            $display("FAIL midload_flags got %b want 1000", {core_reset, mem_we, cpu_ack, ovf});
        end
        checks++;
        if ({mem_addr, mem_din, cpu_data, mod_sel} !== 40'd0 || dip_sw !== 64'd0) begin
            errors++;
            $display("FAIL midload_regs got %h dip=%h want 0",
                     {mem_addr, mem_din, cpu_data, mod_sel}, dip_sw);
        end
        tick();
        dl = 1'b0;
        measure_hold(n);
        checks++;
        if (n !== HOLD + 1) begin
            errors++;
            $display("FAIL midload_hold_len got %0d want %0d", n, HOLD + 1);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL timeout cyc=%0d", cyc);
        $fatal(1, "timeout");
    end

    initial begin
        reset    = 1'b1;
        dl       = 1'b0;
        wr       = 1'b0;
        ioaddr   = '0;
        iodout   = '0;
        idx      = '0;
        cpu_rd   = 1'b0;
        cpu_addr = '0;
        test_reset();
        test_rom_load();
        test_overflow();
        test_options();
        test_cpu_read();
        test_abort();
        test_reset_midload();
        tick();
        tick();
        checks++;
        if (wq.size() !== 0 || rq.size() !== 0) begin
            errors++;
            $display("FAIL final_queues got wq=%0d rq=%0d want 0 0", wq.size(), rq.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
